// File: rtl/frame_pattern_tx.sv
// Test-pattern video source: streams RGB444 frames over a
// valid/ready link with SOP/EOP framing and an inter-frame gap.
module frame_pattern_tx #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int FRAME_GAP    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [11:0] solid_colour,
  input  logic [8:0]  box_x0,
  input  logic [8:0]  box_x1,
  input  logic [7:0]  box_y0,
  input  logic [7:0]  box_y1,
  output logic [11:0] data_out,
  output logic        valid,
  input  logic        ready,
  output logic        startofpacket,
  output logic        endofpacket,
  output logic [15:0] frame_count,
  output logic        busy
);

  localparam int XW =
    (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int YW =
    (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
  localparam int GW =
    (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam int BAR_W =
    (IMAGE_WIDTH / 8 > 0) ? IMAGE_WIDTH / 8 : 1;

  localparam logic [XW-1:0] X_MAX = XW'(IMAGE_WIDTH - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(IMAGE_HEIGHT - 1);
  localparam logic [GW-1:0] G_MAX = GW'(FRAME_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_GAP
  } state_t;

  typedef struct packed {
    logic [1:0]  sel;
    logic [11:0] col;
    logic [8:0]  x0;
    logic [8:0]  x1;
    logic [7:0]  y0;
    logic [7:0]  y1;
  } cfg_t;

  state_t        r_state;
  state_t        w_next;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_nx;
  logic [YW-1:0] w_ny;
  logic [GW-1:0] r_gap;
  cfg_t          r_cfg;
  cfg_t          w_live;
  cfg_t          w_cfg;
  logic [11:0]   r_data;
  logic [11:0]   w_pix;
  logic          r_sop;
  logic          r_eop;
  logic [15:0]   r_frame_cnt;
  logic          w_xfer;
  logic          w_last;
  logic          w_nlast;
  logic          w_start;

  // Pixel colour as a pure function of frame settings and position.
  function automatic logic [11:0] f_pix(
    input cfg_t          c,
    input logic [XW-1:0] px,
    input logic [YW-1:0] py
  );
    logic [31:0] xe;
    logic [31:0] ye;
    logic [31:0] bar;
    logic        in_box;
    logic [11:0] res;
    xe  = 32'(px);
    ye  = 32'(py);
    bar = xe / 32'(BAR_W);
    if (bar > 32'd7) bar = 32'd7;
    in_box = (xe >= 32'(c.x0)) && (xe < 32'(c.x1)) &&
             (ye >= 32'(c.y0)) && (ye < 32'(c.y1));
    res = 12'h000;
    unique case (c.sel)
      2'd0: res = c.col;
      2'd1: begin
        case (bar[2:0])
          3'd0:    res = 12'hFFF;
          3'd1:    res = 12'hFF0;
          3'd2:    res = 12'h0FF;
          3'd3:    res = 12'h0F0;
          3'd4:    res = 12'hF0F;
          3'd5:    res = 12'hF00;
          3'd6:    res = 12'h00F;
          default: res = 12'h000;
        endcase
      end
      2'd2:    res = in_box ? c.col : 12'h000;
      default: res = {xe[3:0], ye[3:0], 4'h0};
    endcase
    return res;
  endfunction

  assign w_xfer  = (r_state == S_STREAM) && ready;
  assign w_last  = (r_x == X_MAX) && (r_y == Y_MAX);
  assign w_start = (w_next == S_STREAM) &&
                   (r_state != S_STREAM);

  // Snapshot of the live settings, taken at frame start.
  always_comb begin
    w_live     = '0;
    w_live.sel = pattern_sel;
    w_live.col = solid_colour;
    w_live.x0  = box_x0;
    w_live.x1  = box_x1;
    w_live.y0  = box_y0;
    w_live.y1  = box_y1;
  end

  // Next raster position and the pixel registered for it.
  always_comb begin
    w_nx = r_x;
    w_ny = r_y;
    if (w_start) begin
      w_nx = '0;
      w_ny = '0;
    end else if (r_x == X_MAX) begin
      w_nx = '0;
      w_ny = (r_y == Y_MAX) ? '0 : r_y + 1'b1;
    end else begin
      w_nx = r_x + 1'b1;
    end
    w_cfg   = w_start ? w_live : r_cfg;
    w_pix   = f_pix(w_cfg, w_nx, w_ny);
    w_nlast = (w_nx == X_MAX) && (w_ny == Y_MAX);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // FSM next state: frames always run to completion.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (enable) w_next = S_STREAM;
      end
      S_STREAM: begin
        if (w_xfer && w_last) w_next = S_GAP;
      end
      S_GAP: begin
        if (r_gap == G_MAX)
          w_next = enable ? S_STREAM : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Gap length counter, cleared outside the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)             r_gap <= '0;
    else if (r_state == S_GAP) r_gap <= r_gap + 1'b1;
    else                      r_gap <= '0;
  end

  // Raster position, frame settings and output beat registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_cfg  <= '0;
      r_data <= 12'h000;
      r_sop  <= 1'b0;
      r_eop  <= 1'b0;
    end else begin
      if (w_start) r_cfg <= w_live;
      if (w_start || (w_xfer && !w_last)) begin
        r_x    <= w_nx;
        r_y    <= w_ny;
        r_data <= w_pix;
        r_sop  <= w_start;
        r_eop  <= w_nlast;
      end else if (w_xfer) begin
        r_data <= 12'h000;
        r_sop  <= 1'b0;
        r_eop  <= 1'b0;
      end
    end
  end

  // Completed-frame counter, bumped on the EOP transfer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_frame_cnt <= 16'h0000;
    else if (w_xfer && w_last)
      r_frame_cnt <= r_frame_cnt + 16'h0001;
  end

  assign data_out      = r_data;
  assign valid         = (r_state == S_STREAM);
  assign startofpacket = r_sop;
  assign endofpacket   = r_eop;
  assign frame_count   = r_frame_cnt;
  assign busy          = (r_state != S_IDLE);

endmodule
